// File: rtl/cov_skew_feeder_if.sv
// Snapshot-in / skewed-edge-out bundle of the covariance array feeder.
// The master side supplies snapshots and observes the skewed edge lanes.
// The slave side is the feeder itself.
interface cov_skew_feeder_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16
);
  logic                         s_valid;
  logic                         s_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] s_data_q;
  logic [NUM_CH*DATA_WIDTH-1:0] s_data_i;
  logic [NUM_CH*DATA_WIDTH-1:0] edge_q;
  logic [NUM_CH*DATA_WIDTH-1:0] edge_i;
  logic [NUM_CH-1:0]            finish;
  logic                         busy;
  logic                         frame_done;

  modport master (
    output s_valid, s_data_q, s_data_i,
    input  s_ready, edge_q, edge_i, finish, busy, frame_done
  );

  modport slave (
    input  s_valid, s_data_q, s_data_i,
    output s_ready, edge_q, edge_i, finish, busy, frame_done
  );
endinterface

// File: rtl/cov_skew_feeder.sv
// Covariance array feeder: counts 2^SAMPLES_BITS snapshots per frame and
// re-emits channel k delayed by k extra cycles. This forms the diagonal
// wavefront the systolic PEs expect. Each lane carries a finish tag on its
// last sample. Zeros are driven whenever no sample is present.
module cov_skew_feeder #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLES_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  cov_skew_feeder_if.slave bus
);

  localparam int VW    = NUM_CH * DATA_WIDTH;
  localparam int CNT_W = (SAMPLES_BITS > 0) ? SAMPLES_BITS : 1;
  localparam int FL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  // With SAMPLES_BITS=0 the counter never leaves 0, so every accept is the last.
  localparam logic [CNT_W-1:0] CNT_LAST = (SAMPLES_BITS > 0) ? {CNT_W{1'b1}} : '0;
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(NUM_CH - 1);
  localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [FL_W-1:0]  fcnt, fcnt_nxt;
  logic             ready, busy, done;
  logic             accept, last_acc;

  // Common input register: captured snapshot, or zeros on gap/flush cycles.
  logic [VW-1:0]    q_p0, i_p0;
  logic             tag_p0;

  // Control registers: frame state, sample counter, flush countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state, handshake and status decode; ready depends on state only.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    ready     = (state != FLUSH);
    busy      = (state != IDLE);
    done      = 1'b0;
    accept    = bus.s_valid && ready;
    last_acc  = accept && (cnt == CNT_LAST);

    case (state)
      IDLE, STREAM: begin
        if (last_acc) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
          fcnt_nxt  = FL_LOAD;
        end else if (accept) begin
          state_nxt = STREAM;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      FLUSH: begin
        // Lane NUM_CH-1 still has its last sample in flight. It leaves on the
        // cycle after this countdown ends, which is when s_ready returns.
        fcnt_nxt = fcnt - 1'b1;
        if (fcnt == FL_ONE) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        fcnt_nxt  = '0;
      end
    endcase
  end

  assign bus.s_ready    = ready;
  assign bus.busy       = busy;
  assign bus.frame_done = done;

  // Stage p0: register the accepted snapshot (or zeros) and the last-sample tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_p0   <= '0;
      i_p0   <= '0;
      tag_p0 <= 1'b0;
    end else begin
      q_p0   <= accept ? bus.s_data_q : '0;
      i_p0   <= accept ? bus.s_data_i : '0;
      tag_p0 <= last_acc;
    end
  end

  // Lane 0 comes straight from the input register; lane k adds k stages.
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      if (k == 0) begin : g_direct
        assign bus.edge_q[0 +: DATA_WIDTH] = q_p0[0 +: DATA_WIDTH];
        assign bus.edge_i[0 +: DATA_WIDTH] = i_p0[0 +: DATA_WIDTH];
        assign bus.finish[0]               = tag_p0;
      end else begin : g_delay
        logic signed [DATA_WIDTH-1:0] q_p1 [k];
        logic signed [DATA_WIDTH-1:0] i_p1 [k];
        logic                         fin_p1 [k];

        // Stages p1..pk: k-deep shift of this channel's I/Q and its finish tag.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < k; j++) begin
              q_p1[j]   <= '0;
              i_p1[j]   <= '0;
              fin_p1[j] <= 1'b0;
            end
          end else begin
            q_p1[0]   <= q_p0[k*DATA_WIDTH +: DATA_WIDTH];
            i_p1[0]   <= i_p0[k*DATA_WIDTH +: DATA_WIDTH];
            fin_p1[0] <= tag_p0;
            for (int j = 1; j < k; j++) begin
              q_p1[j]   <= q_p1[j-1];
              i_p1[j]   <= i_p1[j-1];
              fin_p1[j] <= fin_p1[j-1];
            end
          end
        end

        assign bus.edge_q[k*DATA_WIDTH +: DATA_WIDTH] = q_p1[k-1];
        assign bus.edge_i[k*DATA_WIDTH +: DATA_WIDTH] = i_p1[k-1];
        assign bus.finish[k]                          = fin_p1[k-1];
      end
    end
  endgenerate

endmodule

// File: tb/tb_cov_skew_feeder.sv
// Bench for cov_skew_feeder: a per-lane expected-output scoreboard for a
// 4-channel, 4-sample-frame instance, plus a single-sample-frame instance.
module tb_cov_skew_feeder;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int SB     = 2;
  localparam int FRAME  = 1 << SB;
  localparam int VW     = NUM_CH * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cov_skew_feeder_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus_a ();
  cov_skew_feeder_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus_b ();

  cov_skew_feeder #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SAMPLES_BITS(SB)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  cov_skew_feeder #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SAMPLES_BITS(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] i;
    logic          fin;
  } lane_t;

  lane_t lane_sb [NUM_CH][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_cnt, m_flush, acc_cnt, done_cyc, base, b_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc%0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk_vec(input int n, input bit neg);
    logic signed [DW-1:0] v;
    mk_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v = DW'(16 * n + k);
      if (neg) v = -v;
      mk_vec[k*DW +: DW] = v;
    end
  endfunction

  // Lane k shows the input driven k+1 cycles earlier, so it starts with k+1 zeros.
  task automatic sb_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      lane_sb[k].delete();
      repeat (k + 1) lane_sb[k].push_back('0);
    end
    m_cnt   = 0;
    m_flush = 0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_edge_q"}, bus_a.edge_q, '0);
    chk({tag, "_edge_i"}, bus_a.edge_i, '0);
    chk({tag, "_finish"}, 64'(bus_a.finish), '0);
    chk({tag, "_ready"}, 64'(bus_a.s_ready), 64'd1);
    chk({tag, "_busy"}, 64'(bus_a.busy), '0);
    chk({tag, "_done"}, 64'(bus_a.frame_done), '0);
  endtask

  // One clock: check this cycle's outputs at negedge, then drive next inputs.
  task automatic step(input bit va, input int na, input bit vb);
    lane_t         e;
    logic [VW-1:0] xq, xi, dq, di;
    logic [NUM_CH-1:0] xf;
    bit            acc, last;

    @(negedge clk);
    if (b_cyc >= 0) b_cyc++;

    xq = '0; xi = '0; xf = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      e = lane_sb[k].pop_front();
      xq[k*DW +: DW] = e.q;
      xi[k*DW +: DW] = e.i;
      xf[k]          = e.fin;
    end
    chk("a_edge_q", bus_a.edge_q, xq);
    chk("a_edge_i", bus_a.edge_i, xi);
    chk("a_finish", 64'(bus_a.finish), 64'(xf));
    chk("a_ready", 64'(bus_a.s_ready), 64'(m_flush == 0));
    chk("a_busy", 64'(bus_a.busy), 64'(m_cnt > 0 || m_flush > 0));
    chk("a_done", 64'(bus_a.frame_done), 64'(m_flush == 1));
    if (bus_a.frame_done === 1'b1) done_cyc = cyc;

    // Single-sample frame accepted at b_cyc 0: lane k shows it at b_cyc 1+k.
    xq = '0; xi = '0; xf = '0;
    if (b_cyc >= 1 && b_cyc <= NUM_CH) begin
      dq = mk_vec(0, 1'b0);
      di = mk_vec(0, 1'b1);
      xq[(b_cyc-1)*DW +: DW] = dq[(b_cyc-1)*DW +: DW];
      xi[(b_cyc-1)*DW +: DW] = di[(b_cyc-1)*DW +: DW];
      xf[b_cyc-1] = 1'b1;
    end
    chk("b_edge_q", bus_b.edge_q, xq);
    chk("b_edge_i", bus_b.edge_i, xi);
    chk("b_finish", 64'(bus_b.finish), 64'(xf));
    chk("b_ready", 64'(bus_b.s_ready), 64'(!(b_cyc >= 1 && b_cyc <= NUM_CH - 1)));
    chk("b_busy", 64'(bus_b.busy), 64'(b_cyc >= 1 && b_cyc <= NUM_CH - 1));
    chk("b_done", 64'(bus_b.frame_done), 64'(b_cyc == NUM_CH - 1));

    // Drive DUT A and record what each lane must show later.
    dq  = mk_vec(na, 1'b0);
    di  = mk_vec(na, 1'b1);
    acc = va && (m_flush == 0);
    last = acc && (m_cnt == FRAME - 1);
    bus_a.s_valid  = va;
    bus_a.s_data_q = va ? dq : {$urandom, $urandom};
    bus_a.s_data_i = va ? di : {$urandom, $urandom};
    for (int k = 0; k < NUM_CH; k++) begin
      e.q   = acc ? dq[k*DW +: DW] : '0;
      e.i   = acc ? di[k*DW +: DW] : '0;
      e.fin = last;
      lane_sb[k].push_back(e);
    end
    if (m_flush > 0) begin
      m_flush--;
    end else if (acc) begin
      acc_cnt++;
      if (m_cnt == FRAME - 1) begin
        m_cnt   = 0;
        m_flush = NUM_CH - 1;
      end else begin
        m_cnt++;
      end
    end

    // Drive DUT B.
    bus_b.s_valid  = vb;
    bus_b.s_data_q = vb ? mk_vec(0, 1'b0) : {$urandom, $urandom};
    bus_b.s_data_i = vb ? mk_vec(0, 1'b1) : {$urandom, $urandom};
    if (vb) b_cyc = 0;

    cyc++;
  endtask

  initial begin
    b_cyc          = -1;
    acc_cnt        = 0;
    done_cyc       = -1;
    bus_a.s_valid  = 1'b0;
    bus_a.s_data_q = '0;
    bus_a.s_data_i = '0;
    bus_b.s_valid  = 1'b0;
    bus_b.s_data_q = '0;
    bus_b.s_data_i = '0;
    sb_reset();

    repeat (2) @(negedge clk);
    chk_reset_a("rst");
    rst = 1'b0;

    // Idle: gaps only.
    repeat (10) step(1'b0, 0, 1'b0);

    // Four back-to-back snapshots.
    base = cyc;
    for (int n = 0; n < FRAME; n++) step(1'b1, n, 1'b0);
    repeat (5) step(1'b0, 0, 1'b0);
    chk("done_cyc_full", 64'(done_cyc - base), 64'd6);

    // Same frame with gaps at cycles 1 and 2.
    base = cyc;
    step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b1, 3, 1'b0);
    repeat (6) step(1'b0, 0, 1'b0);
    chk("done_cyc_gap", 64'(done_cyc - base), 64'd8);

    // s_valid held high through two frames: no accept during flush.
    base    = cyc;
    acc_cnt = 0;
    for (int c = 0; c < 14; c++) step(1'b1, c, 1'b0);
    repeat (6) step(1'b0, 0, 1'b0);
    chk("b2b_accepts", 64'(acc_cnt), 64'd8);
    chk("done_cyc_b2b", 64'(done_cyc - base), 64'd13);

    // Reset in cycle 2 of a frame, then a clean frame.
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b0);
    @(negedge clk);
    rst           = 1'b1;
    bus_a.s_valid = 1'b0;
    #1;
    chk_reset_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    sb_reset();
    base = cyc;
    for (int n = 0; n < FRAME; n++) step(1'b1, n, 1'b0);
    repeat (5) step(1'b0, 0, 1'b0);
    chk("done_cyc_after_rst", 64'(done_cyc - base), 64'd6);

    // Single-sample frame on the SAMPLES_BITS=0 instance.
    step(1'b0, 0, 1'b1);
    repeat (NUM_CH + 3) step(1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cov_skew_feeder.md
# cov_skew_feeder

Upstream feeder for the covariance systolic array. Accepts one complex snapshot vector of all NUM_CH antenna channels per handshake and counts exactly 2^SAMPLES_BITS snapshots per frame. Re-emits channel k delayed by k extra cycles, giving the diagonal wavefront that the array's PEs need at the edges. Marks the last sample of every channel with a per-channel finish flag, so each PE outputs its averaged product and clears its accumulator in step. Drives zeros whenever no sample is present, because the PEs accumulate on every clock.

## Interface
- NUM_CH, 4: number of antenna channels, i.e. array rows and columns; at least 2.
- DATA_WIDTH, 16: signed width of each I and Q sample.
- SAMPLES_BITS, 4: log2 of the number of snapshots per frame; equals the PE's averaging shift.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  a snapshot is present on s_data_q and s_data_i.
- s_ready  out  1  the feeder can accept a snapshot this cycle.
- s_data_q  in  NUM_CH*DATA_WIDTH  Q part of each channel, signed; channel k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_data_i  in  NUM_CH*DATA_WIDTH  I part, packed the same way as s_data_q.
- edge_q  out  NUM_CH*DATA_WIDTH  skewed Q per channel; the top level fans it out to both the row and the column edges.
- edge_i  out  NUM_CH*DATA_WIDTH  skewed I per channel, same fan-out.
- finish  out  NUM_CH  bit k is high on the cycle edge lane k carries the frame's last sample.
- busy  out  1  high while in STREAM or FLUSH.
- frame_done  out  1  one-cycle pulse when the flush completes.

## Operation
- A snapshot is accepted on a cycle with s_valid=1 and s_ready=1.
- States and transitions:
  - IDLE: s_ready=1, busy=0. An accept in IDLE is sample 0 of a new frame; move to STREAM.
  - STREAM: s_ready=1, busy=1. Each accept increments sample counter cnt (SAMPLES_BITS wide). The accept with cnt = 2^SAMPLES_BITS-1 is the last sample; move to FLUSH and load a flush counter with NUM_CH-1.
  - FLUSH: s_ready=0, busy=1. The flush counter decrements each cycle. When it reaches 0, pulse frame_done and return to IDLE.
- Gap cycles (s_valid=0 in IDLE or STREAM) inject an all-zero vector with finish bit 0. The frame length still counts accepted samples only.
- Skew: lane k is a k-stage delay line behind one common input register. Every data stage and every finish stage is cleared by reset.
- finish injection: the last-sample tag enters all lanes on the cycle of the last accept, and it travels with lane k's data.
- Data passes through unmodified, with no arithmetic and no width change.
- cnt wraps to 0 on the last accept. No partial frames exist: a frame ends only after 2^SAMPLES_BITS accepts or on rst.
- If SAMPLES_BITS=0, the first accept in IDLE is also the last; go straight to FLUSH.
- rst mid-frame: state goes to IDLE, cnt and the flush counter go to 0, all delay lines clear, and the partial frame is discarded. The downstream array must be reset together with this block.

## Timing
- Reset values: s_ready=1, busy=0, frame_done=0, finish=0, edge_q=0, edge_i=0.
- Latency: a sample accepted at cycle t appears on lane k at cycle t+1+k.
- The last sample's finish bit k is high exactly at t_last+1+k. Only one finish bit is high per cycle, except that lanes coincide when NUM_CH=1 (not supported).
- FLUSH lasts NUM_CH-1 cycles. frame_done pulses in the last FLUSH cycle, which is cycle t_last+NUM_CH-1.
- s_ready rises again on the cycle after frame_done. Lane NUM_CH-1 emits its last sample at t_last+NUM_CH, the cycle after frame_done.
- Back-to-back frames: the first sample of the next frame is accepted at the earliest at t_last+NUM_CH. Its lane-0 output at t_last+NUM_CH+1 never overlaps the previous frame on any lane.
- s_ready is combinational from state only and does not depend on s_valid.

## Test plan
- Reset, then set NUM_CH=4, SAMPLES_BITS=2. Hold s_valid=0 for 10 cycles -> edge_q, edge_i and finish stay 0; s_ready=1; busy=0.
- Send 4 consecutive snapshots, with channel k of sample n set to q=16*n+k and i=-(16*n+k), starting at t=0 -> lane k shows value n at cycle n+1+k. finish[k] is high only at cycle 4+k. frame_done pulses at cycle 6. s_ready=0 during cycles 4 to 6.
- Same frame with s_valid low at cycles 1 and 2 -> lanes carry zeros in the matching skewed slots. finish[0] comes 2 cycles later, at cycle 6. cnt counts only the 4 accepts.
- Drive s_valid=1 continuously through two frames -> no accept happens in FLUSH. The second frame's sample 0 is accepted at cycle 7. No lane mixes data from the two frames.
- Assert rst at cycle 2 of a frame -> all outputs return to reset values immediately. After release, a full 4-sample frame behaves exactly as in the 4-snapshot scenario.
- Set SAMPLES_BITS=0 and send a single sample -> finish[k] is high at cycle 1+k, frame_done pulses at cycle NUM_CH-1, and the block returns to IDLE.
